// File: rtl/mdio_pkg.sv
// MDIO master shared definitions: frame field encodings,
// state enumeration and frame-length constants.
package mdio_pkg;

    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    localparam logic [1:0] OP_C22_WR    = 2'b01;
    localparam logic [1:0] OP_C22_RD    = 2'b10;
    localparam logic [1:0] OP_C45_ADDR  = 2'b00;
    localparam logic [1:0] OP_C45_WR    = 2'b01;
    localparam logic [1:0] OP_C45_RD    = 2'b11;
    localparam logic [1:0] OP_C45_RDINC = 2'b10;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        TA,
        DATA,
        GAP,
        REJ
    } state_e;

    // What to do with mdio_i on the MDC rising edge of the bit on the bus
    typedef enum logic [1:0] {
        SMP_NONE,
        SMP_ERR,
        SMP_SHIFT
    } smp_e;

    // Every read-type opcode (C22 and C45) has OP[1] set
    function automatic logic is_read(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: per-bit phase counter, MDC low for the first half
// of each bit and high for the second, with bit-start/sample strobes.
module mdio_clk_gen #(
    parameter int CLK_DIV = 80
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic mdc_o,
    output logic bit_start_o,
    output logic sample_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(CLK_DIV / 2);

    logic [PW-1:0] ph_q;
    logic          mdc_q;

    assign bit_start_o = en_i && (ph_q == '0);
    assign sample_o    = en_i && (ph_q == PH_MID);
    assign mdc_o       = mdc_q;

    // Phase counter runs only while enabled; idle parks at ph=0, mdc=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= '0;
            mdc_q <= 1'b0;
        end else if (!en_i) begin
            ph_q  <= '0;
            mdc_q <= 1'b0;
        end else begin
            ph_q <= (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
            if (bit_start_o) begin
                mdc_q <= 1'b0;
            end else if (sample_o) begin
                mdc_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdio_master_gen2.sv
// MDIO management master: Clause 22 / Clause 45 frames to any PHY,
// valid/ready command in, one-cycle response pulse out.
module mdio_master_gen2
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 80,
    parameter int PREAMBLE_LEN = 32,
    parameter int IDLE_GAP     = 1,
    parameter int C45_EN       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] HDR_LAST  = 8'(HDR_BITS - 1);
    localparam logic [7:0] TA_LAST   = 8'(TA_BITS - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_BITS - 1);
    localparam logic [7:0] GAP_END   = 8'(IDLE_GAP);

    state_e        state_q;
    smp_e          smp_q;
    logic [7:0]    cnt_q;
    logic [13:0]   hdr_q;
    logic [13:0]   hdr_d;
    logic [15:0]   wdata_q;
    logic [15:0]   shift_q;
    logic          rd_q;
    logic          err_q;
    logic          cmd_ready_q;
    logic          busy_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          mdio_o_q;
    logic          mdio_oe_q;
    logic          en;
    logic          bit_start;
    logic          sample;

    assign hdr_d = {(cmd_c45 ? ST_C45 : ST_C22), cmd_op, cmd_phyad, cmd_regad};
    assign en    = (state_q != IDLE) && (state_q != REJ);

    mdio_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .mdc_o      (mdc),
        .bit_start_o(bit_start),
        .sample_o   (sample)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;

    // Frame sequencer: each bit_start puts the next frame bit on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            smp_q       <= SMP_NONE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (sample) begin
                case (smp_q)
                    SMP_ERR:   err_q   <= mdio_i;
                    SMP_SHIFT: shift_q <= {shift_q[14:0], mdio_i};
                    default:   ;
                endcase
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        hdr_q       <= hdr_d;
                        wdata_q     <= cmd_wdata;
                        rd_q        <= is_read(cmd_op);
                        err_q       <= 1'b0;
                        shift_q     <= '0;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if ((C45_EN == 0) && cmd_c45) begin
                            state_q <= REJ;
                        end else if (PREAMBLE_LEN == 0) begin
                            state_q <= HDR;
                        end else begin
                            state_q <= PRE;
                        end
                    end
                end
                REJ: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                PRE: begin
                    if (bit_start) begin
                        mdio_o_q  <= 1'b1;
                        mdio_oe_q <= 1'b1;
                        smp_q     <= SMP_NONE;
                        if (cnt_q == PRE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= HDR;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                HDR: begin
                    if (bit_start) begin
                        mdio_o_q  <= hdr_q[13];
                        mdio_oe_q <= 1'b1;
                        smp_q     <= SMP_NONE;
                        hdr_q     <= {hdr_q[12:0], 1'b0};
                        if (cnt_q == HDR_LAST) begin
                            cnt_q   <= '0;
                            state_q <= TA;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                TA: begin
                    if (bit_start) begin
                        if (rd_q) begin
                            mdio_o_q  <= 1'b1;
                            mdio_oe_q <= 1'b0;
                            smp_q     <= (cnt_q == TA_LAST) ? SMP_ERR : SMP_NONE;
                        end else begin
                            mdio_o_q  <= (cnt_q == '0);
                            mdio_oe_q <= 1'b1;
                            smp_q     <= SMP_NONE;
                        end
                        if (cnt_q == TA_LAST) begin
                            cnt_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                DATA: begin
                    if (bit_start) begin
                        if (rd_q) begin
                            mdio_o_q  <= 1'b1;
                            mdio_oe_q <= 1'b0;
                            smp_q     <= SMP_SHIFT;
                        end else begin
                            mdio_o_q  <= wdata_q[15];
                            mdio_oe_q <= 1'b1;
                            smp_q     <= SMP_NONE;
                            wdata_q   <= {wdata_q[14:0], 1'b0};
                        end
                        if (cnt_q == DATA_LAST) begin
                            cnt_q   <= '0;
                            state_q <= GAP;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (bit_start) begin
                        if (cnt_q == GAP_END) begin
                            cnt_q       <= '0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            if (cnt_q == '0) begin
                                mdio_o_q    <= 1'b1;
                                mdio_oe_q   <= 1'b0;
                                smp_q       <= SMP_NONE;
                                rsp_valid_q <= 1'b1;
                                rsp_rdata_q <= rd_q ? shift_q : 16'h0000;
                                rsp_err_q   <= rd_q & err_q;
                            end
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master_gen2.sv
// Bench for mdio_master_gen2: three instances (full preamble,
// no preamble, Clause 45 disabled) checked against a frame-level model.
module tb_mdio_master_gen2;

    localparam int D = 8;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cmd_valid = '0;
    logic        cmd_c45 = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_phyad = '0;
    logic [4:0]  cmd_regad = '0;
    logic [15:0] cmd_wdata = '0;
    logic [2:0]  cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe;
    logic [2:0]  mdio_i = 3'b111;
    logic [15:0] rsp_rdata [3];

    int n_cmp = 0;
    int n_bad = 0;
    int t_now = 0;

    always #5 clk = ~clk;

    mdio_master_gen2 #(.CLK_DIV(D), .PREAMBLE_LEN(32), .IDLE_GAP(G), .C45_EN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]), .mdc(mdc[0]), .mdio_o(mdio_o[0]),
        .mdio_oe(mdio_oe[0]), .mdio_i(mdio_i[0]));

    mdio_master_gen2 #(.CLK_DIV(D), .PREAMBLE_LEN(0), .IDLE_GAP(G), .C45_EN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]), .mdc(mdc[1]), .mdio_o(mdio_o[1]),
        .mdio_oe(mdio_oe[1]), .mdio_i(mdio_i[1]));

    mdio_master_gen2 #(.CLK_DIV(D), .PREAMBLE_LEN(32), .IDLE_GAP(G), .C45_EN(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2]), .mdc(mdc[2]), .mdio_o(mdio_o[2]),
        .mdio_oe(mdio_oe[2]), .mdio_i(mdio_i[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to the falling edge that follows rising edge t (edge 0 = acceptance)
    task automatic adv(input int t);
        repeat (t - t_now) @(posedge clk);
        @(negedge clk);
        t_now = t;
    endtask

    task automatic issue(input int sel, input logic c45, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] regad,
                         input logic [15:0] wd, input bit hold, output int waited);
        cmd_c45 = c45;
        cmd_op = op;
        cmd_phyad = phy;
        cmd_regad = regad;
        cmd_wdata = wd;
        cmd_valid[sel] = 1'b1;
        waited = 0;
        while (!cmd_ready[sel] && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 4000) chk("accept_timeout", 64'(cmd_ready[sel]), 64'd1);
        @(posedge clk);
        t_now = 0;
        #1;
        if (!hold) begin
            cmd_valid[sel] = 1'b0;
            cmd_c45 = 1'($urandom);
            cmd_op = 2'($urandom);
            cmd_phyad = 5'($urandom);
            cmd_regad = 5'($urandom);
            cmd_wdata = 16'($urandom);
        end
    endtask

    // Value a PHY (or the pull-up) presents on mdio_i during frame bit k
    function automatic logic phy_bit(input int k, input int P, input logic rd,
                                     input logic present, input logic [15:0] d);
        if (!(rd && present)) return 1'b1;
        if (k == P + 15) return 1'b0;
        if (k >= P + 16 && k < P + 32) return d[15 - (k - P - 16)];
        return 1'b1;
    endfunction

    task automatic run_frame(input int sel, input int P, input logic c45,
                             input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] regad, input logic [15:0] wd,
                             input logic present, input logic [15:0] pdata,
                             input string tag);
        logic [31:0] tail, tail_oe;
        logic [63:0] oo, ooe, xo, xoe, mlo, mhi, full;
        logic [15:0] exp_rd;
        logic        rd, exp_err;
        int          n, nr;
        rd = op[1];
        tail = {(c45 ? 2'b00 : 2'b01), op, phy, regad,
                (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wd)};
        tail_oe = {14'h3FFF, (rd ? 2'b00 : 2'b11), (rd ? 16'h0000 : 16'hFFFF)};
        n = P + 32;
        oo = '0; ooe = '0; xo = '0; xoe = '0; mlo = '0; mhi = '0; full = '0;
        for (int k = 0; k < n; k++) begin
            xo[k]   = (k < P) ? 1'b1 : tail[31 - (k - P)];
            xoe[k]  = (k < P) ? 1'b1 : tail_oe[31 - (k - P)];
            full[k] = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            adv(1 + k * D + D / 4);
            oo[k]  = mdio_o[sel];
            ooe[k] = mdio_oe[sel];
            mlo[k] = mdc[sel];
            mdio_i[sel] = phy_bit(k, P, rd, present, pdata);
            adv(1 + k * D + 3 * D / 4);
            mhi[k] = mdc[sel];
        end
        mdio_i[sel] = 1'b1;
        chk({tag, "/frame_oe"}, ooe, xoe);
        chk({tag, "/frame_o"}, oo & xoe, xo & xoe);
        chk({tag, "/mdc_low"}, mlo, 64'd0);
        chk({tag, "/mdc_high"}, mhi, full);
        exp_rd  = rd ? (present ? pdata : 16'hFFFF) : 16'h0000;
        exp_err = rd && !present;
        nr = n * D + 1;
        adv(nr - 1);
        chk({tag, "/pre_rsp"}, 64'({rsp_valid[sel], busy[sel], cmd_ready[sel]}), 64'b010);
        adv(nr);
        chk({tag, "/rsp"}, 64'({rsp_valid[sel], rsp_err[sel], rsp_rdata[sel]}),
            64'({1'b1, exp_err, exp_rd}));
        adv(nr + 1);
        chk({tag, "/rsp_pulse"}, 64'(rsp_valid[sel]), 64'd0);
        adv(nr + G * D - 1);
        chk({tag, "/gap_busy"}, 64'({cmd_ready[sel], busy[sel], mdio_oe[sel]}), 64'b010);
        adv(nr + G * D);
        chk({tag, "/idle"}, 64'({cmd_ready[sel], busy[sel], mdc[sel], mdio_oe[sel],
            mdio_o[sel], rsp_err[sel], rsp_rdata[sel]}),
            64'({5'b10001, exp_err, exp_rd}));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cnt;
        logic c45;
        logic [1:0] op;
        logic [4:0] phy, regad;
        logic [15:0] wd, pd;
        logic pres;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++)
            chk($sformatf("reset%0d", s), 64'({cmd_ready[s], busy[s], mdc[s], mdio_o[s],
                mdio_oe[s], rsp_valid[s], rsp_err[s], rsp_rdata[s]}),
                64'({7'b1001000, 16'h0000}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(0, 1'b0, 2'b01, 5'd7, 5'd0, 16'h9140, 1'b0, w);
        run_frame(0, 32, 1'b0, 2'b01, 5'd7, 5'd0, 16'h9140, 1'b0, 16'h0, "c22_wr");

        issue(0, 1'b0, 2'b10, 5'd7, 5'd2, 16'h0, 1'b0, w);
        run_frame(0, 32, 1'b0, 2'b10, 5'd7, 5'd2, 16'h0, 1'b1, 16'h0141, "c22_rd");

        issue(0, 1'b0, 2'b10, 5'd9, 5'd3, 16'h0, 1'b0, w);
        run_frame(0, 32, 1'b0, 2'b10, 5'd9, 5'd3, 16'h0, 1'b0, 16'h0, "c22_nophy");

        issue(0, 1'b1, 2'b00, 5'd7, 5'd1, 16'h0007, 1'b1, w);
        cmd_op = 2'b11;
        cmd_wdata = 16'h5A5A;
        run_frame(0, 32, 1'b1, 2'b00, 5'd7, 5'd1, 16'h0007, 1'b0, 16'h0, "c45_addr");
        issue(0, 1'b1, 2'b11, 5'd7, 5'd1, 16'h5A5A, 1'b0, w);
        chk("b2b_wait", 64'(w), 64'd0);
        run_frame(0, 32, 1'b1, 2'b11, 5'd7, 5'd1, 16'h5A5A, 1'b1, 16'hBEEF, "c45_rd");

        for (int i = 0; i < 4; i++) begin
            c45 = 1'($urandom); op = 2'($urandom); phy = 5'($urandom);
            regad = 5'($urandom); wd = 16'($urandom); pd = 16'($urandom);
            pres = 1'($urandom);
            issue(0, c45, op, phy, regad, wd, 1'b0, w);
            run_frame(0, 32, c45, op, phy, regad, wd, pres, pd, $sformatf("rand%0d", i));
        end

        issue(2, 1'b1, 2'b11, 5'd4, 5'd1, 16'h1234, 1'b0, w);
        adv(0);
        chk("rej_e0", 64'({rsp_valid[2], cmd_ready[2], busy[2], mdc[2]}), 64'b0010);
        adv(1);
        chk("rej_rsp", 64'({rsp_valid[2], rsp_err[2], cmd_ready[2], busy[2], rsp_rdata[2]}),
            64'({4'b1110, 16'h0000}));
        adv(2);
        chk("rej_pulse", 64'(rsp_valid[2]), 64'd0);
        cnt = 0;
        for (int i = 3; i < 40; i++) begin
            adv(i);
            cnt += int'(mdc[2]) + int'(mdio_oe[2]);
        end
        chk("rej_nobus", 64'(cnt), 64'd0);

        issue(0, 1'b0, 2'b01, 5'd3, 5'd4, 16'hC3A5, 1'b0, w);
        adv(1 + (32 + 21) * D + D / 4);
        rst_n = 1'b0;
        #1;
        chk("abort", 64'({cmd_ready[0], busy[0], mdc[0], mdio_o[0], mdio_oe[0],
            rsp_valid[0], rsp_err[0], rsp_rdata[0]}), 64'({7'b1001000, 16'h0000}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 64 * D + 20; i++) begin
            @(negedge clk);
            cnt += int'(rsp_valid[0]);
        end
        chk("abort_norsp", 64'(cnt), 64'd0);

        issue(1, 1'b0, 2'b01, 5'd1, 5'd0, 16'h9140, 1'b0, w);
        run_frame(1, 0, 1'b0, 2'b01, 5'd1, 5'd0, 16'h9140, 1'b0, 16'h0, "np_wr");
        pd = 16'($urandom);
        issue(1, 1'b0, 2'b10, 5'd1, 5'd1, 16'h0, 1'b0, w);
        run_frame(1, 0, 1'b0, 2'b10, 5'd1, 5'd1, 16'h0, 1'b1, pd, "np_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
